// File: rtl/alu.sv
// alu: registered eight-op ALU with carry/borrow flag and one-cycle latency.
module alu #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry
);
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic [WIDTH:0]   sum, diff;
    // The extra MSB of the widened difference is the borrow, set exactly when a < b.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    always_comb begin
        out_d   = '0;
        carry_d = 1'b0;
        case (opcode)
            3'b000: {carry_d, out_d} = sum;
            3'b001: {carry_d, out_d} = diff;
            3'b010: out_d = a & b;
            3'b011: out_d = a | b;
            3'b100: out_d = a ^ b;
            3'b101: out_d = ~a;
            3'b110: out_d = ~(a & b);
            3'b111: out_d = ~(a | b);
            default: out_d = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end
    assign alu_out = out_q;
    assign carry   = carry_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors plus per-cycle comparison of alu against an arithmetic model.
module tb_alu;
    localparam int W = 1;
    localparam int M = 1 << W;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   opcode = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] alu_out;
    logic         carry;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] exp_out;
    logic         exp_carry;
    logic         exp_valid = 1'b0;
    alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .a(a), .b(b),
        .alu_out(alu_out), .carry(carry)
    );
    always #5 clk = ~clk;
    // Returns {carry, result} computed with integer arithmetic on unsigned operands.
    function automatic logic [W:0] model(input logic [2:0] op, input int ai, input int bi);
        int o;
        int c;
        c = 0;
        case (op)
            3'd0: begin o = (ai + bi) % M; c = (ai + bi >= M) ? 1 : 0; end
            3'd1: begin o = (ai - bi + M) % M; c = (ai < bi) ? 1 : 0; end
            3'd2: o = ai & bi;
            3'd3: o = ai | bi;
            3'd4: o = ai ^ bi;
            3'd5: o = (M - 1) - ai;
            3'd6: o = (M - 1) - (ai & bi);
            default: o = (M - 1) - (ai | bi);
        endcase
        return {c[0], o[W-1:0]};
    endfunction
    always @(posedge clk) begin
        exp_valid <= 1'b1;
        {exp_carry, exp_out} <= rst ? '0 : model(opcode, int'(a), int'(b));
    end
    always @(negedge clk) begin
        if (exp_valid) begin
            n_cmp = n_cmp + 1;
            if (alu_out !== exp_out || carry !== exp_carry) begin
                n_bad = n_bad + 1;
                $display("FAIL model: op=%0d a=%0d b=%0d got out=%0d c=%0d want out=%0d c=%0d",
                         opcode, a, b, alu_out, carry, exp_out, exp_carry);
            end
        end
    end
    task automatic step(input logic r, input logic [2:0] op, input int ai, input int bi,
                        input bit chk, input int eo, input int ec, input string name);
        rst = r; opcode = op; a = ai[W-1:0]; b = bi[W-1:0];
        @(posedge clk);
        @(negedge clk);
        #1;
        if (chk) begin
            n_cmp = n_cmp + 1;
            if (alu_out !== eo[W-1:0] || carry !== ec[0]) begin
                n_bad = n_bad + 1;
                $display("FAIL %s: got out=%0d c=%0d want out=%0d c=%0d", name, alu_out, carry, eo, ec);
            end
        end
    endtask
    initial begin
        int sweep_o[8] = '{1, 1, 0, 1, 1, 0, 1, 0};
        @(negedge clk);
        step(1, 3'd0, 1, 1, 1, 0, 0, "reset0");
        step(1, 3'd0, 1, 1, 1, 0, 0, "reset1");
        for (int i = 0; i < 8; i++) step(0, i[2:0], 1, 0, 1, sweep_o[i], 0, "sweep");
        step(0, 3'd0, 1, 1, 1, 0, 1, "add_carry");
        step(0, 3'd2, 1, 1, 1, 1, 0, "and_clears_carry");
        step(0, 3'd1, 0, 1, 1, 1, 1, "sub_borrow");
        step(0, 3'd1, 1, 1, 1, 0, 0, "sub_no_borrow");
        for (int op = 0; op < 8; op++)
            for (int x = 0; x < M; x++)
                for (int y = 0; y < M; y++)
                    step(0, op[2:0], x, y, 0, 0, 0, "exhaustive");
        step(0, 3'd0, 1, 1, 1, 0, 1, "pre_reset_add");
        step(1, 3'd0, 1, 1, 1, 0, 0, "mid_reset");
        step(0, 3'd0, 1, 1, 1, 0, 1, "post_reset_add");
        step(0, 3'd7, 0, 0, 1, 1, 0, "nor_zero");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
